// File: rtl/i2s_tx_serializer_if.sv
// rtl/i2s_tx_serializer_if.sv - PCM sample-pair handshake bundle for the I2S transmitter
interface i2s_tx_serializer_if;
    logic [15:0] din_l;
    logic [15:0] din_r;
    logic        din_valid;
    logic        din_ready;

    modport master (output din_l, output din_r, output din_valid, input din_ready);
    modport slave  (input din_l, input din_r, input din_valid, output din_ready);
endinterface

// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - Philips I2S transmitter with one-pair holding register
module i2s_tx_serializer #(
    parameter int BCLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    i2s_tx_serializer_if.slave    pcm,
    output logic                  bclk,
    output logic                  lrck,
    output logic                  sdata,
    output logic                  frame_start,
    output logic                  underrun
);

    localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

    logic [7:0]  div_cnt;
    logic [4:0]  slot;
    logic [31:0] active;   // {left, right} of the frame on the wire
    logic [31:0] holding;  // next pair waiting for a frame boundary
    logic        full;

    logic        tick;
    logic        fall;
    logic        load;
    logic        accept;
    logic [4:0]  slot_next;
    logic [4:0]  bit_idx;

    // Event decode: divider wrap, bclk falling edge, frame boundary, handshake
    always_comb begin
        tick      = (div_cnt == DIV_LAST);
        fall      = tick && bclk;
        slot_next = slot + 5'd1;
        // Slot s carries active[32-s]; slot 0 thus picks active[0] of the frame
        // being retired, which is the delayed right-channel LSB.
        bit_idx   = 5'd0 - slot_next;
        load      = fall && (slot_next == 5'd0);
        accept    = pcm.din_valid && !full;
    end

    assign pcm.din_ready = ~full;

    // Bit-clock divider: bclk toggles every BCLK_DIV clk cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= 8'd0;
            bclk    <= 1'b0;
        end else if (tick) begin
            div_cnt <= 8'd0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    // Slot sequencing and serial output, advanced on bclk falling edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot        <= 5'd31;
            lrck        <= 1'b1;
            sdata       <= 1'b0;
            active      <= 32'd0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            if (fall) begin
                slot  <= slot_next;
                lrck  <= slot_next[4];
                sdata <= active[bit_idx];
            end
            if (load) begin
                frame_start <= 1'b1;
                if (full) begin
                    active <= holding;
                end else begin
                    // A pair accepted on this very edge is not yet visible here,
                    // so it waits in holding for the following frame.
                    active   <= 32'd0;
                    underrun <= 1'b1;
                end
            end
        end
    end

    // Holding register: filled on accept, emptied when a frame boundary consumes it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            holding <= 32'd0;
            full    <= 1'b0;
        end else if (accept) begin
            holding <= {pcm.din_l, pcm.din_r};
            full    <= 1'b1;
        end else if (load && full) begin
            full <= 1'b0;
        end
    end

endmodule
